lsu_mem_ctrl: RTL and testbench

//  Load/store unit between the MEM pipeline stage and the word-wide data memory.
//  - Accepts one load/store request per valid/ready handshake.
//  - Converts byte/half/word accesses into word-wide memory reads and writes.
//  - Sub-word stores use read-modify-write; loads get lane select and sign/zero extension.
//  - Flags misaligned and out-of-range accesses.

---
 rtl/lsu_mem_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: word-wide memory access with sub-word read-modify-write stores.
// Define LSU_MISALIGN_EXC_EN to turn misaligned half/word accesses into errors.
module lsu_mem_ctrl #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_waddr_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] mem_raddr_o,
    input  logic [31:0] mem_rdata_i
);

    // state  | meaning
    // IDLE   | ready for a request; response pulse of the previous op
    // LOAD   | read word, extract lane, register result
    // RMW_RD | read word, merge store lane into merge register
    // STORE  | single-cycle memory write
    // ERR    | no memory activity, error response next cycle
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_STORE,
        S_ERR
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t      state_q, state_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;

    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic        misalign;
    logic        req_err;
    logic [31:0] word_addr;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    assign req_ready_o  = (state_q == S_IDLE) && !rst;
    assign accept       = req_valid_i && req_ready_o;
    assign word_addr    = {addr_q[31:2], 2'b00};
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

    always_comb begin
        misalign = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
        misalign = ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                   ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
`endif
        req_err = (req_size_i == SZ_RSVD) || (req_addr_i >= 32'(MEM_BYTES)) || misalign;
    end

    // Lane extraction; with misalignment allowed the ignored low bits simply drop out.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   lane_b = mem_rdata_i[7:0];
            2'b01:   lane_b = mem_rdata_i[15:8];
            2'b10:   lane_b = mem_rdata_i[23:16];
            default: lane_b = mem_rdata_i[31:24];
        endcase
        lane_h = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (size_q)
            SZ_BYTE: load_val = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_HALF: load_val = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_val = mem_rdata_i;
        endcase
    end

    always_comb begin
        merge_val = mem_rdata_i;
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'b00:   merge_val[7:0]   = wdata_q[7:0];
                2'b01:   merge_val[15:8]  = wdata_q[7:0];
                2'b10:   merge_val[23:16] = wdata_q[7:0];
                default: merge_val[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_val[31:16] = wdata_q[15:0];
        end else begin
            merge_val[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_waddr_o = 32'b0;
        mem_wdata_o = 32'b0;
        mem_raddr_o = 32'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)                   state_d = S_ERR;
                    else if (!req_we_i)            state_d = S_LOAD;
                    else if (req_size_i == SZ_WORD) state_d = S_STORE;
                    else                           state_d = S_RMW_RD;
                end
            end
            S_LOAD: begin
                mem_raddr_o = word_addr;
                state_d     = S_IDLE;
            end
            S_RMW_RD: begin
                mem_raddr_o = word_addr;
                state_d     = S_STORE;
            end
            S_STORE: begin
                // Gated by rst so an abandoned store never reaches memory.
                mem_req_o   = !rst;
                mem_we_o    = !rst;
                mem_waddr_o = word_addr;
                mem_wdata_o = (size_q == SZ_WORD) ? wdata_q : merge_q;
                mem_raddr_o = word_addr;
                state_d     = S_IDLE;
            end
            S_ERR: begin
                mem_raddr_o = word_addr;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= 32'b0;
            wdata_q      <= 32'b0;
            merge_q      <= 32'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= 1'b0;
            if (accept) begin
                we_q    <= req_we_i;
                size_q  <= req_size_i;
                uns_q   <= req_unsigned_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            case (state_q)
                S_LOAD: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= load_val;
                    resp_err_q   <= 1'b0;
                end
                S_RMW_RD: merge_q <= merge_val;
                S_STORE: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= 32'b0;
                    resp_err_q   <= 1'b0;
                end
                S_ERR: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= 32'b0;
                    resp_err_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // we_q is kept for debug visibility of the in-flight request.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases plus random traffic against a byte-array reference model.
module tb_lsu_mem_ctrl;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        resp_valid_o, resp_err_o;
    logic [31:0] resp_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_waddr_o, mem_wdata_o, mem_raddr_o, mem_rdata_i;

    lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o),
        .mem_wdata_o(mem_wdata_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    logic [31:0] tb_mem [0:MEM_BYTES/4-1];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];
    int cyc = 0, wr_cnt = 0, last_wr_cyc = 0, rst_wr = 0;
    int n_checks = 0, n_pass = 0;

    assign mem_rdata_i = tb_mem[mem_raddr_o[9:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req_o && mem_we_o) begin
            tb_mem[mem_waddr_o[9:2]] <= mem_wdata_o;
            wr_cnt      <= wr_cnt + 1;
            last_wr_cyc <= cyc;
            if (rst) rst_wr <= rst_wr + 1;
            if (mem_waddr_o[1:0] != 2'b00) rst_wr <= rst_wr + 100;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic is_err(input logic [1:0] size, input logic [31:0] addr);
        logic e;
        e = (size == 2'd3) || (addr >= MEM_BYTES);
`ifdef LSU_MISALIGN_EXC_EN
        if (size == 2'd1 && addr[0]) e = 1'b1;
        if (size == 2'd2 && addr[1:0] != 2'b00) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic int eff_addr(input logic [1:0] size, input logic [31:0] addr);
        int a;
        a = int'(addr);
        if (size == 2'd1) a = a - (a % 2);
        if (size == 2'd2) a = a - (a % 4);
        return a;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
        int a, nb;
        logic [31:0] v;
        a  = eff_addr(size, addr);
        nb = 1 << size;
        v  = 0;
        for (int k = 0; k < nb; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
        if (size == 2'd0 && !uns && v[7])  v = v | 32'hFFFF_FF00;
        if (size == 2'd1 && !uns && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got);
        int lat, acc, wr0, n, exp_lat, exp_wr, a;
        logic e;
        logic [31:0] exp_d;
        e       = is_err(size, addr);
        exp_lat = (!e && we && size != 2'd2) ? 3 : 2;
        exp_wr  = (!e && we) ? 1 : 0;
        exp_d   = (!e && !we) ? exp_load(size, uns, addr) : 32'h0;
        @(negedge clk);
        req_we_i = we; req_size_i = size; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wdata; req_valid_i = 1'b1;
        n = 0;
        while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
        check("ready_before_accept", 32'(req_ready_o), 32'd1);
        wr0 = wr_cnt;
        @(posedge clk); #1;
        acc = cyc;
        req_valid_i = 1'b0;
        lat = 1;
        while (lat < 9) begin
            @(posedge clk); #1;
            lat++;
            if (resp_valid_o) break;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_err", 32'(resp_err_o), 32'(e));
        check("resp_rdata", resp_rdata_o, exp_d);
        check("write_count", 32'(wr_cnt - wr0), 32'(exp_wr));
        if (exp_wr == 1) check("write_cycle", 32'(last_wr_cyc - acc), 32'(exp_lat - 2));
        got = resp_rdata_o;
        if (exp_wr == 1) begin
            a = eff_addr(size, addr);
            for (int k = 0; k < (1 << size); k++) ref_mem[a + k] = wdata[8*k +: 8];
        end
    endtask

    logic [31:0] r;
    logic [31:0] w;
    int seen;

    initial begin
        for (int i = 0; i < MEM_BYTES / 4; i++) begin
            w = $urandom;
            tb_mem[i] = w;
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
        end
        rst = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
        req_unsigned_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_resp_rdata", resp_rdata_o, 32'd0);
        check("rst_resp_err", 32'(resp_err_o), 32'd0);
        check("rst_mem_req_we", {30'd0, mem_req_o, mem_we_o}, 32'd0);
        check("rst_raddr", mem_raddr_o, 32'd0);
        rst = 1'b0;
        #1 check("ready_after_rst", 32'(req_ready_o), 32'd1);

        do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, r);
        do_req(0, 2'd2, 0, 32'h10, 32'h0, r);
        check("t1_lw", r, 32'hDEADBEEF);

        do_req(1, 2'd2, 0, 32'h10, 32'h11223344, r);
        do_req(1, 2'd0, 0, 32'h13, 32'h000000A5, r);
        do_req(0, 2'd2, 0, 32'h10, 32'h0, r);
        check("t2_merged", r, 32'hA5223344);
        do_req(0, 2'd0, 0, 32'h13, 32'h0, r);
        check("t2_lb", r, 32'hFFFFFFA5);
        do_req(0, 2'd0, 1, 32'h13, 32'h0, r);
        check("t2_lbu", r, 32'h000000A5);

        do_req(1, 2'd2, 0, 32'h20, 32'h0, r);
        do_req(1, 2'd1, 0, 32'h22, 32'h00008001, r);
        do_req(0, 2'd2, 0, 32'h20, 32'h0, r);
        check("t3_word", r, 32'h80010000);
        do_req(0, 2'd1, 0, 32'h22, 32'h0, r);
        check("t3_lh", r, 32'hFFFF8001);
        do_req(0, 2'd1, 1, 32'h22, 32'h0, r);
        check("t3_lhu", r, 32'h00008001);

        do_req(0, 2'd2, 0, 32'h05, 32'h0, r);
`ifdef LSU_MISALIGN_EXC_EN
        check("t4_misalign", r, 32'h0);
`else
        check("t4_misalign", r, {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]});
`endif
        do_req(0, 2'd2, 0, 32'h400, 32'h0, r);
        check("t6_oor_err", 32'(resp_err_o), 32'd1);
        do_req(1, 2'd3, 0, 32'h40, 32'h12345678, r);

        // Reset during RMW_RD: the store must never reach memory.
        seen = wr_cnt;
        @(negedge clk);
        req_we_i = 1; req_size_i = 2'd0; req_addr_i = 32'h30; req_wdata_i = 32'h5A; req_valid_i = 1;
        @(posedge clk); #1;
        req_valid_i = 0; rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        #1 check("t5_ready_after_rst", 32'(req_ready_o), 32'd1);
        n_checks = n_checks;
        begin
            int pulses = 0;
            repeat (5) begin @(posedge clk); #1; if (resp_valid_o) pulses++; end
            check("t5_no_resp", 32'(pulses), 32'd0);
        end
        check("t5_no_write", 32'(wr_cnt - seen), 32'd0);

        // Request held valid through the response cycle is accepted there.
        @(negedge clk);
        req_we_i = 0; req_size_i = 2'd2; req_unsigned_i = 0; req_addr_i = 32'h10; req_valid_i = 1;
        @(posedge clk); #1;
        req_addr_i = 32'h20;
        @(posedge clk); #1;
        check("b2b_resp1_valid", 32'(resp_valid_o), 32'd1);
        check("b2b_resp1_data", resp_rdata_o, exp_load(2'd2, 0, 32'h10));
        check("b2b_ready_in_resp", 32'(req_ready_o), 32'd1);
        @(posedge clk); #1;
        req_valid_i = 0;
        check("b2b_gap", 32'(resp_valid_o), 32'd0);
        @(posedge clk); #1;
        check("b2b_resp2_valid", 32'(resp_valid_o), 32'd1);
        check("b2b_resp2_data", resp_rdata_o, exp_load(2'd2, 0, 32'h20));

        for (int i = 0; i < 150; i++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = ($urandom_range(0, 9) == 0) ? 32'(MEM_BYTES + $urandom_range(0, 5000))
                                              : 32'($urandom_range(0, MEM_BYTES - 1));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, r);
        end
        for (int i = 0; i < MEM_BYTES / 4; i += 17) begin
            do_req(0, 2'd2, 0, 32'(4 * i), 32'h0, r);
        end
        check("no_write_in_rst", 32'(rst_wr), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
